ysyx_25040111_trapseq: RTL and testbench
========================================

YSYX_25040111_TRAPSEQ -- requirements
Module: ysyx_25040111_trapseq

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; all state changes on posedge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 SHALL have: req_valid in 1; req_ready out 1; req_type in 3 (0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal); req_pc in 32; req_csr in 12; req_src in 32.
REQ-004 SHALL have: resp_valid out 1; resp_rdata out 32 (old CSR value for rd); resp_redirect out 1; resp_target out 32; resp_illegal out 1.
REQ-005 SHALL have CSR-file port: csr_ren out 1; csr_raddr out 12; csr_rdata in 32 (combinational, same-cycle); csr_wen out 1; csr_waddr out 12; csr_wdata out 32; csr_jtype out 4.

Function
REQ-006 SHALL implement FSM states IDLE, RD, WR, EPC, CAUSE, RESP; one state per cycle; no state repeats.
REQ-007 IDLE: req_ready=1; on req_valid&req_ready SHALL latch type/pc/csr/src and go to RD (illegal type -> RESP directly).
REQ-008 req_ready SHALL be 0 in every state except IDLE; one request in flight max.
REQ-009 RD: csr_ren=1; csr_raddr = latched csr (CSR ops), 0x305 (ECALL), 0x341 (MRET); SHALL capture csr_rdata into old register at end of cycle.
REQ-010 RD next: CSR ops -> WR; ECALL -> EPC; MRET -> RESP.
REQ-011 WR: csr_waddr = latched csr; csr_wdata = src (RW), old|src (RS), old&~src (RC); csr_wen=1 except RS/RC with src==0, where csr_wen=0; next RESP.
REQ-012 EPC: csr_wen=1, csr_waddr=0x341, csr_wdata=latched pc; next CAUSE.
REQ-013 CAUSE: csr_jtype=4'b0001, csr_wen=0 (CSR file records mcause=11); next RESP.
REQ-014 csr_jtype SHALL be 4'b0000 in every state other than CAUSE; csr_wen/csr_ren SHALL be 0 outside WR/EPC and RD respectively.
REQ-015 RESP: resp_valid=1 for exactly one cycle; next IDLE; resp_* held 0 whenever resp_valid=0.
REQ-016 RESP fields: CSR ops -> resp_rdata=old, redirect=0; ECALL -> redirect=1, target=old (mtvec); MRET -> redirect=1, target=old (mepc); illegal -> resp_illegal=1, others 0.
REQ-017 Latency from accepting edge to resp_valid: CSR op 3 cycles, ECALL 4, MRET 2, illegal 1.
REQ-018 Unmapped req_csr SHALL still be sequenced; CSR file returns 0 and ignores write; no error flagged.
REQ-019 Next request SHALL be accepted no earlier than the cycle after RESP (no back-to-back with RESP).

Reset
REQ-020 reset SHALL force IDLE and clear latched fields and old register to 0.
REQ-021 During and after reset: req_ready=1 once reset deasserts; resp_*, csr_ren, csr_wen=0, csr_jtype=0, addresses/data 0.
REQ-022 Reset mid-operation SHALL abort the sequence; CSR writes already issued remain, none further issued, no resp_valid produced.

Configuration
REQ-023 Macro YSYX_25040111_TRAPSEQ_ALIGN_EN defined: resp_target[1:0] SHALL be forced to 2'b00 for ECALL and MRET.
REQ-024 Macro undefined: resp_target SHALL equal the raw CSR value read in RD.

Verification
REQ-025 CSRRW csr=0x305 src=0x80000100, CSR read 0x0 -> write 0x305<=0x80000100 in WR; 3 cycles later resp_rdata=0x0, redirect=0.
REQ-026 CSRRS csr=0x300 src=0x0, CSR read 0x1800 -> csr_wen never 1; resp_rdata=0x1800.
REQ-027 ECALL pc=0x80000040, mtvec=0x80000101 -> EPC writes 0x341<=0x80000040, CAUSE jtype=1, resp target 0x80000100 (ALIGN_EN) / 0x80000101 (not), redirect=1, 4 cycles.
REQ-028 MRET with mepc=0x80000044 -> no csr_wen; resp_target=0x80000044, redirect=1, 2 cycles after accept.
REQ-029 req_type=6 -> resp_illegal=1 next cycle, no CSR access; reset asserted during EPC of an ECALL -> no CAUSE, no resp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/ysyx_25040111_trapseq_if.sv
// Bus bundle for the trap/CSR sequencer: request/response handshake, CSR-file
// port and a debug view of the sequencer state.
interface ysyx_25040111_trapseq_if;
  // A request transfers on a clock edge where req_valid and req_ready are both 1.
  // The requester holds its fields stable while req_valid=1 and req_ready=0.
  // resp_valid is a single-cycle pulse and has no backpressure.
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_pc;
  logic [11:0] req_csr;
  logic [31:0] req_src;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic        resp_illegal;

  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_jtype;

  logic [2:0]  dbg_state;

  modport slave (
    input  req_valid, req_type, req_pc, req_csr, req_src, csr_rdata,
    output req_ready, resp_valid, resp_rdata, resp_redirect, resp_target,
           resp_illegal, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
           csr_jtype, dbg_state
  );

  modport master (
    output req_valid, req_type, req_pc, req_csr, req_src, csr_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_redirect, resp_target,
           resp_illegal, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
           csr_jtype, dbg_state
  );
endinterface

// File: rtl/ysyx_25040111_trapseq.sv
// Trap/CSR sequencer: steps CSRRW/CSRRS/CSRRC, ECALL and MRET through the CSR file.
// Define YSYX_25040111_TRAPSEQ_ALIGN_EN to clear resp_target[1:0] on redirects.
module ysyx_25040111_trapseq (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_25040111_trapseq_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_EPC   = 3'd3,
    S_CAUSE = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  localparam logic [2:0]  T_CSRRW = 3'd0;
  localparam logic [2:0]  T_CSRRS = 3'd1;
  localparam logic [2:0]  T_CSRRC = 3'd2;
  localparam logic [2:0]  T_ECALL = 3'd3;
  localparam logic [2:0]  T_MRET  = 3'd4;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC  = 12'h341;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [11:0] csr_q, csr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] old_q, old_d;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic        resp_illegal;
  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_jtype;
  logic [31:0] redirect_target;
  logic        type_is_csr;

  assign type_is_csr = (type_q == T_CSRRW) || (type_q == T_CSRRS) || (type_q == T_CSRRC);

`ifdef YSYX_25040111_TRAPSEQ_ALIGN_EN
  assign redirect_target = {old_q[31:2], 2'b00};
`else
  assign redirect_target = old_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= 3'd0;
      pc_q    <= 32'd0;
      csr_q   <= 12'd0;
      src_q   <= 32'd0;
      old_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      csr_q   <= csr_d;
      src_q   <= src_d;
      old_q   <= old_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    pc_d          = pc_q;
    csr_d         = csr_q;
    src_d         = src_q;
    old_d         = old_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'd0;
    resp_redirect = 1'b0;
    resp_target   = 32'd0;
    resp_illegal  = 1'b0;
    csr_ren       = 1'b0;
    csr_raddr     = 12'd0;
    csr_wen       = 1'b0;
    csr_waddr     = 12'd0;
    csr_wdata     = 32'd0;
    csr_jtype     = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          type_d  = bus.req_type;
          pc_d    = bus.req_pc;
          csr_d   = bus.req_csr;
          src_d   = bus.req_src;
          // Illegal types skip the CSR file entirely.
          state_d = (bus.req_type > T_MRET) ? S_RESP : S_RD;
        end
      end

      S_RD: begin
        csr_ren = 1'b1;
        if (type_q == T_ECALL)     csr_raddr = CSR_MTVEC;
        else if (type_q == T_MRET) csr_raddr = CSR_MEPC;
        else                       csr_raddr = csr_q;
        old_d = bus.csr_rdata;
        if (type_is_csr)           state_d = S_WR;
        else if (type_q == T_ECALL) state_d = S_EPC;
        else                       state_d = S_RESP;
      end

      S_WR: begin
        csr_waddr = csr_q;
        if (type_q == T_CSRRS)      csr_wdata = old_q | src_q;
        else if (type_q == T_CSRRC) csr_wdata = old_q & ~src_q;
        else                        csr_wdata = src_q;
        // Set/clear with a zero mask must not write (read-only CSRs stay untouched).
        csr_wen = (type_q == T_CSRRW) || (src_q != 32'd0);
        state_d = S_RESP;
      end

      S_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
        state_d   = S_CAUSE;
      end

      S_CAUSE: begin
        csr_jtype = 4'b0001;
        state_d   = S_RESP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        if (type_is_csr) begin
          resp_rdata = old_q;
        end else if ((type_q == T_ECALL) || (type_q == T_MRET)) begin
          resp_redirect = 1'b1;
          resp_target   = redirect_target;
        end else begin
          resp_illegal = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_rdata    = resp_rdata;
  assign bus.resp_redirect = resp_redirect;
  assign bus.resp_target   = resp_target;
  assign bus.resp_illegal  = resp_illegal;
  assign bus.csr_ren       = csr_ren;
  assign bus.csr_raddr     = csr_raddr;
  assign bus.csr_wen       = csr_wen;
  assign bus.csr_waddr     = csr_waddr;
  assign bus.csr_wdata     = csr_wdata;
  assign bus.csr_jtype     = csr_jtype;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ysyx_25040111_trapseq.sv
// Directed table-driven bench for the trap/CSR sequencer, plus hand sequences
// for back-to-back requests and reset in the middle of an ECALL.
module tb_ysyx_25040111_trapseq;

`ifdef YSYX_25040111_TRAPSEQ_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  logic [11:0] cur_raddr;
  logic [31:0] cur_rval;

  ysyx_25040111_trapseq_if bus ();

  ysyx_25040111_trapseq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // CSR-file stand-in: returns the table value only for the expected address.
  assign bus.csr_rdata = (bus.csr_ren && (bus.csr_raddr == cur_raddr)) ? cur_rval : 32'hDEAD_BEEF;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] pc;
    logic [11:0] csr;
    logic [31:0] src;
    logic [31:0] rval;
    logic [11:0] exp_raddr;
    int          exp_lat;
    int          exp_ren_n;
    int          exp_wen_n;
    logic [11:0] exp_waddr;
    logic [31:0] exp_wdata;
    int          exp_jt_n;
    logic        exp_redir;
    logic [31:0] exp_target;
    logic        exp_ill;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, ren_n, wen_n, jt_n, busy_ready;
    logic [11:0] raddr_s, waddr_s;
    logic [31:0] wdata_s, rdata_s, target_s, exp_word;
    logic [3:0]  jt_s;
    logic        redir_s, ill_s;
    lat = 0; ren_n = 0; wen_n = 0; jt_n = 0; busy_ready = 0;
    raddr_s = 0; waddr_s = 0; wdata_s = 0; rdata_s = 0; target_s = 0;
    jt_s = 0; redir_s = 0; ill_s = 0;
    cur_raddr = v.exp_raddr;
    cur_rval  = v.rval;
    exp_q.push_back(v.exp_redir ? v.exp_target : v.exp_rdata);

    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_type  = v.typ;
    bus.req_pc    = v.pc;
    bus.req_csr   = v.csr;
    bus.req_src   = v.src;
    check($sformatf("v%0d ready_idle", idx), {31'd0, bus.req_ready}, 32'd1);
    @(posedge clock);
    #1;
    // Scramble the request fields so only the latched copies can be used.
    bus.req_valid = 1'b0;
    bus.req_type  = 3'($urandom_range(0, 7));
    bus.req_pc    = $urandom;
    bus.req_csr   = 12'($urandom_range(0, 4095));
    bus.req_src   = $urandom;

    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (bus.req_ready) busy_ready++;
      if (bus.csr_ren) begin ren_n++; raddr_s = bus.csr_raddr; end
      if (bus.csr_wen) begin wen_n++; waddr_s = bus.csr_waddr; wdata_s = bus.csr_wdata; end
      if (bus.csr_jtype != 4'd0) begin jt_n++; jt_s = bus.csr_jtype; end
      if (bus.resp_valid) begin
        lat      = n;
        rdata_s  = bus.resp_rdata;
        target_s = bus.resp_target;
        redir_s  = bus.resp_redirect;
        ill_s    = bus.resp_illegal;
        break;
      end
    end

    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d ready_busy", idx), busy_ready, 0);
    check($sformatf("v%0d ren_cycles", idx), ren_n, v.exp_ren_n);
    if (v.exp_ren_n > 0) check($sformatf("v%0d raddr", idx), {20'd0, raddr_s}, {20'd0, v.exp_raddr});
    check($sformatf("v%0d wen_cycles", idx), wen_n, v.exp_wen_n);
    if (v.exp_wen_n > 0) begin
      check($sformatf("v%0d waddr", idx), {20'd0, waddr_s}, {20'd0, v.exp_waddr});
      check($sformatf("v%0d wdata", idx), wdata_s, v.exp_wdata);
    end
    check($sformatf("v%0d jtype_cycles", idx), jt_n, v.exp_jt_n);
    if (v.exp_jt_n > 0) check($sformatf("v%0d jtype", idx), {28'd0, jt_s}, 32'd1);
    check($sformatf("v%0d redirect", idx), {31'd0, redir_s}, {31'd0, v.exp_redir});
    check($sformatf("v%0d illegal", idx), {31'd0, ill_s}, {31'd0, v.exp_ill});
    exp_word = exp_q.pop_front();
    if (v.exp_redir) check($sformatf("v%0d target", idx), target_s, exp_word);
    else             check($sformatf("v%0d rdata", idx), rdata_s, exp_word);

    @(negedge clock);
    check($sformatf("v%0d resp_drop", idx), {31'd0, bus.resp_valid}, 32'd0);
    check($sformatf("v%0d ready_after", idx), {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic check_quiet(input string name);
    check({name, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({name, " state"}, {29'd0, bus.dbg_state}, 32'd0);
    check({name, " outs"},
          {bus.resp_valid, bus.resp_redirect, bus.resp_illegal, bus.csr_ren, bus.csr_wen,
           bus.csr_jtype, 25'd0}, 32'd0);
    check({name, " buses"}, bus.resp_rdata | bus.resp_target | bus.csr_wdata |
          {20'd0, bus.csr_raddr} | {20'd0, bus.csr_waddr}, 32'd0);
  endtask

  initial begin
    int resp_n, jt_n, wen_n, notready_n;
    logic [2:0] exp_states [5];

    //            typ   pc            csr     src           rval          raddr   lat ren wen waddr   wdata         jt redir target        ill rdata
    vecs[0]  = '{3'd0, 32'h0,        12'h305, 32'h80000100, 32'h0,        12'h305, 3, 1, 1, 12'h305, 32'h80000100, 0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{3'd1, 32'h0,        12'h300, 32'h0,        32'h1800,     12'h300, 3, 1, 0, 12'h0,   32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h1800};
    vecs[2]  = '{3'd1, 32'h0,        12'h300, 32'h8,        32'h1800,     12'h300, 3, 1, 1, 12'h300, 32'h1808,     0, 1'b0, 32'h0,        1'b0, 32'h1800};
    vecs[3]  = '{3'd2, 32'h0,        12'h300, 32'h800,      32'h1808,     12'h300, 3, 1, 1, 12'h300, 32'h1008,     0, 1'b0, 32'h0,        1'b0, 32'h1808};
    vecs[4]  = '{3'd2, 32'h0,        12'h342, 32'h0,        32'h5,        12'h342, 3, 1, 0, 12'h0,   32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h5};
    vecs[5]  = '{3'd3, 32'h80000040, 12'h123, 32'h55,       32'h80000101, 12'h305, 4, 1, 1, 12'h341, 32'h80000040, 1, 1'b1, 32'h80000101, 1'b0, 32'h0};
    vecs[6]  = '{3'd4, 32'h0,        12'h0,   32'h0,        32'h80000044, 12'h341, 2, 1, 0, 12'h0,   32'h0,        0, 1'b1, 32'h80000044, 1'b0, 32'h0};
    vecs[7]  = '{3'd6, 32'h1234,     12'h305, 32'hFFFF,     32'h0,        12'h0,   1, 0, 0, 12'h0,   32'h0,        0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{3'd5, 32'h0,        12'h300, 32'h1,        32'h0,        12'h0,   1, 0, 0, 12'h0,   32'h0,        0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{3'd7, 32'h0,        12'h341, 32'h0,        32'h0,        12'h0,   1, 0, 0, 12'h0,   32'h0,        0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{3'd0, 32'h0,        12'h7FF, 32'h12345678, 32'h0,        12'h7FF, 3, 1, 1, 12'h7FF, 32'h12345678, 0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{3'd4, 32'h0,        12'h0,   32'h0,        32'h80000046, 12'h341, 2, 1, 0, 12'h0,   32'h0,        0, 1'b1, 32'h80000046, 1'b0, 32'h0};
    vecs[5].exp_target  = ALIGN ? 32'h80000100 : 32'h80000101;
    vecs[11].exp_target = ALIGN ? 32'h80000044 : 32'h80000046;

    cur_raddr = 12'h0;
    cur_rval  = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_type  = 3'd0;
    bus.req_pc    = 32'd0;
    bus.req_csr   = 12'd0;
    bus.req_src   = 32'd0;

    // Reset.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("in_reset");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("post_reset");

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Held req_valid: MRET -> RD, RESP, then IDLE before the next accept.
    exp_states[0] = 3'd1; exp_states[1] = 3'd5; exp_states[2] = 3'd0;
    exp_states[3] = 3'd1; exp_states[4] = 3'd5;
    cur_raddr = 12'h341;
    cur_rval  = 32'h80000080;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd4;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      check($sformatf("b2b state%0d", n), {29'd0, bus.dbg_state}, {29'd0, exp_states[n]});
    end
    bus.req_valid = 1'b0;
    @(negedge clock);
    check("b2b idle", {29'd0, bus.dbg_state}, 32'd0);

    // Reset while the ECALL is writing mepc.
    cur_raddr = 12'h305;
    cur_rval  = 32'h80000200;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd3;
    bus.req_pc    = 32'h80000300;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    check("rst_seq rd", {31'd0, bus.csr_ren}, 32'd1);
    @(negedge clock);
    check("rst_seq epc_wen", {31'd0, bus.csr_wen}, 32'd1);
    check("rst_seq epc_data", bus.csr_wdata, 32'h80000300);
    reset = 1'b1;
    @(negedge clock);
    check_quiet("rst_seq held");
    reset = 1'b0;
    resp_n = 0; jt_n = 0; wen_n = 0; notready_n = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (bus.resp_valid) resp_n++;
      if (bus.csr_jtype != 4'd0) jt_n++;
      if (bus.csr_wen) wen_n++;
      if (!bus.req_ready) notready_n++;
    end
    check("rst_seq no_resp", resp_n, 0);
    check("rst_seq no_cause", jt_n, 0);
    check("rst_seq no_wen", wen_n, 0);
    check("rst_seq ready", notready_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
